// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO; optional even parity (8E1).
// Latency: a byte written into an empty, idle block drives the start bit from the next clk edge.
// Backpressure: ready drops when the FIFO is full; a write while full is silently dropped.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_acc;
  logic             pop;
  logic [7:0]       head;

  // Transmitter state
  state_t            state, state_nxt;
  logic              tx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic              baud_end;

`ifdef UART_TX_PARITY_EN
  logic par, par_nxt;
`endif

  // ready reflects occupancy before the edge, so a pop in the same cycle never frees a slot early
  assign ready    = (count != FULL_CNT);
  assign busy     = (state != IDLE) | (count != '0);
  assign wr_acc   = wr_en & ready;
  assign head     = mem[rd_ptr];
  assign baud_end = (baud_cnt == BAUD_LAST);

  // FIFO data array: no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous write and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmitter registers; tx is registered so the line only moves on clk edges
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tx       <= tx_nxt;
      shift    <= shift_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
`ifdef UART_TX_PARITY_EN
      par      <= par_nxt;
`endif
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    shift_nxt = shift;
    baud_nxt  = baud_end ? '0 : baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_idx;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif

    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = head;
          tx_nxt    = 1'b0;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^head;
`endif
        end else begin
          tx_nxt = 1'b1;
        end
      end

      START: begin
        if (baud_end) begin
          tx_nxt    = shift[0];
          bit_nxt   = '0;
          state_nxt = DATA;
        end
      end

      DATA: begin
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_nxt    = par;
            state_nxt = PARITY;
`else
            tx_nxt    = 1'b1;
            state_nxt = STOP;
`endif
          end else begin
            // shift[1] is the bit that lands in shift[0] after this shift
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
            bit_nxt   = bit_idx + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif

      STOP: begin
        if (baud_end) begin
          if (count != '0) begin
            // chain straight into the next start bit, no idle-high gap
            pop       = 1'b1;
            shift_nxt = head;
            tx_nxt    = 1'b0;
            state_nxt = START;
`ifdef UART_TX_PARITY_EN
            par_nxt   = ^head;
`endif
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4, FIFO_DEPTH=4.
// A per-cycle vector table covers reset and a single frame; captured tx waveforms
// are compared frame by frame against a bit-level frame model for the multi-cycle cases.
module tb_uart_tx_fifo;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FL = NSLOT * CLK_DIV;

  logic       clk     = 1'b0;
  logic       rstn    = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready;
  logic       busy;
  logic       tx;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .ready   (ready),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // tx capture: one sample per clk, 1 time unit after the edge
  logic       cap_en = 1'b0;
  logic       cap[$];
  logic [7:0] exp_bytes[$];

  always @(posedge clk) begin
    #1;
    if (cap_en) cap.push_back(tx);
  end

  typedef struct {
    logic       rstn;
    logic       wr;
    logic [7:0] d;
    int         n;
    logic       tx;
    logic       busy;
    logic       ready;
  } vec_t;

  vec_t vec[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Expected tx per clk within one frame, bit c = value c clocks after the start bit began
  function automatic logic [63:0] frame_vec(input logic [7:0] b);
    logic [63:0] v;
    logic        bv;
    v = '0;
    for (int c = 0; c < FL; c++) begin
      int s;
      s = c / CLK_DIV;
      if (s == 0)              bv = 1'b0;
      else if (s <= 8)         bv = b[s-1];
      else if (s == NSLOT - 1) bv = 1'b1;
      else                     bv = ^b;
      v[c] = bv;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic begin_cap();
    cap.delete();
    exp_bytes.delete();
    cap_en = 1'b1;
  endtask

  // cap[0] is tx after the first write edge; frames follow back-to-back, then idle
  task automatic check_frames(input string nm);
    int need;
    int guard;
    need  = 1 + exp_bytes.size() * FL + 1;
    guard = 0;
    while (cap.size() < need && guard < 3000) begin
      step();
      guard++;
    end
    if (cap.size() < need) begin
      chk({nm, " capture timeout"}, 64'(cap.size()), 64'(need));
    end else begin
      chk({nm, " lead idle"}, 64'(cap[0]), 64'd1);
      for (int f = 0; f < exp_bytes.size(); f++) begin
        logic [63:0] act;
        act = '0;
        for (int c = 0; c < FL; c++) act[c] = cap[1 + f * FL + c];
        chk($sformatf("%s frame%0d", nm, f), act, frame_vec(exp_bytes[f]));
      end
      chk({nm, " tail idle"}, 64'(cap[need-1]), 64'd1);
      chk({nm, " busy after"}, 64'(busy), 64'd0);
    end
    cap_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- table: reset, then a single 0x55 frame cycle by cycle ----
    vec.push_back('{1'b0, 1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b1});   // reset state
    vec.push_back('{1'b1, 1'b1, 8'h55, 1, 1'b1, 1'b1, 1'b1});   // accept, line still idle
    vec.push_back('{1'b1, 1'b0, 8'h00, 4, 1'b0, 1'b1, 1'b1});   // start bit
    for (int i = 0; i < 8; i++)                                 // 0x55 LSB first: 1,0,1,0,...
      vec.push_back('{1'b1, 1'b0, 8'h00, 4, (i % 2 == 0), 1'b1, 1'b1});
`ifdef UART_TX_PARITY_EN
    vec.push_back('{1'b1, 1'b0, 8'h00, 4, 1'b0, 1'b1, 1'b1});   // even parity of 0x55
`endif
    vec.push_back('{1'b1, 1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b1});   // stop bit
    vec.push_back('{1'b1, 1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b1});   // idle, busy low

    foreach (vec[i]) begin
      rstn    = vec[i].rstn;
      wr_en   = vec[i].wr;
      wr_data = vec[i].d;
      for (int j = 0; j < vec[i].n; j++) begin
        step();
        chk($sformatf("vec%0d.%0d tx", i, j),    64'(tx),    64'(vec[i].tx));
        chk($sformatf("vec%0d.%0d busy", i, j),  64'(busy),  64'(vec[i].busy));
        chk($sformatf("vec%0d.%0d ready", i, j), 64'(ready), 64'(vec[i].ready));
      end
    end
    wr_en = 1'b0;
    step();

    // ---- back-to-back: 0xA5 then 0x3C, no idle gap ----
    begin_cap();
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h3C);
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    check_frames("b2b");

    // ---- overflow: 0x01..0x06, 0x06 dropped ----
    begin_cap();
    for (int i = 1; i <= 5; i++) exp_bytes.push_back(8'(i));
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      if (i == 5) chk("ovf ready before 5", 64'(ready), 64'd1);
      if (i == 6) chk("ovf ready before 6", 64'(ready), 64'd0);
      step();
    end
    wr_en = 1'b0;
    check_frames("ovf");

    // ---- reset during data bit 3 with two bytes queued ----
    wr_en = 1'b1; wr_data = 8'hC3;
    step();
    wr_data = 8'h5A;
    step();
    wr_data = 8'hF0;
    step();
    wr_en = 1'b0;
    repeat (15) step();                        // now just after edge N+17: data bit 3
    chk("rst pre bit3 tx", 64'(tx), 64'd0);    // bit 3 of 0xC3 is 0
    rstn = 1'b0;
    step();
    chk("rst tx", 64'(tx), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ready", 64'(ready), 64'd1);
    rstn = 1'b1;
    begin
      int act_cnt;
      act_cnt = 0;
      repeat (60) begin
        step();
        if (tx !== 1'b1 || busy !== 1'b0) act_cnt++;
      end
      chk("rst quiet cycles", 64'(act_cnt), 64'd0);
    end
    begin_cap();
    exp_bytes.push_back(8'h81);
    wr_en = 1'b1; wr_data = 8'h81;
    step();
    wr_en = 1'b0;
    check_frames("post rst");

    // ---- write on the STOP pop while full ----
    begin_cap();
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    exp_bytes.push_back(8'h33);
    exp_bytes.push_back(8'h44);
    exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'h66);
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 * i);
      step();
    end
    wr_en = 1'b0;
    chk("pop full ready", 64'(ready), 64'd0);
    repeat (FL - 4) step();                    // just after edge N+FL, pop comes at N+FL+1
    chk("pop pre ready", 64'(ready), 64'd0);
    wr_en = 1'b1; wr_data = 8'hEE;             // dropped: full before the pop edge
    step();
    chk("pop post ready", 64'(ready), 64'd1);
    wr_data = 8'h66;                           // accepted, FIFO back to 4
    step();
    wr_en = 1'b0;
    chk("pop refill ready", 64'(ready), 64'd0);
    check_frames("pop");

`ifdef UART_TX_PARITY_EN
    // ---- parity: 0x07 -> parity bit 1, 44-clock frame ----
    begin_cap();
    exp_bytes.push_back(8'h07);
    wr_en = 1'b1; wr_data = 8'h07;
    step();
    wr_en = 1'b0;
    check_frames("parity");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
